// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial WIDTH-bit subtractor, LSB first, borrow flip-flop
// Optional signed-overflow output enabled by defining SERIAL_SUB_OVF_EN.
module serial_subtractor #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_borrow,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_diff,
   output logic             out_borrow
`ifdef SERIAL_SUB_OVF_EN
   ,
   output logic             out_ovf
`endif
);

   localparam int CNT_W = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-2:0] res_q, res_d;
   logic [WIDTH-1:0] diff_q, diff_d;
   logic             br_q, br_d;
   logic             bout_q, bout_d;
`ifdef SERIAL_SUB_OVF_EN
   logic             ovf_q, ovf_d;
`endif

   logic             bit_a, bit_b, bit_d, br_next, last_bit;
   logic [WIDTH-1:0] res_full;

   // Full-subtractor cell on the current LSBs and the borrow flip-flop
   assign bit_a    = a_q[0];
   assign bit_b    = b_q[0];
   assign bit_d    = bit_a ^ bit_b ^ br_q;
   assign br_next  = (~bit_a & bit_b) | (~(bit_a ^ bit_b) & br_q);
   assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));
   assign res_full = {bit_d, res_q};

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      a_d     = a_q;
      b_d     = b_q;
      res_d   = res_q;
      diff_d  = diff_q;
      br_d    = br_q;
      bout_d  = bout_q;
`ifdef SERIAL_SUB_OVF_EN
      ovf_d   = ovf_q;
`endif
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               a_d     = in_a;
               b_d     = in_b;
               br_d    = in_borrow;
               cnt_d   = '0;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            res_d = res_full[WIDTH-1:1];
            a_d   = a_q >> 1;
            b_d   = b_q >> 1;
            br_d  = br_next;
            cnt_d = cnt_q + CNT_W'(1);
            // Result registers only change here, so they hold the last result elsewhere
            if (last_bit) begin
               diff_d  = res_full;
               bout_d  = br_next;
`ifdef SERIAL_SUB_OVF_EN
               ovf_d   = br_q ^ br_next;
`endif
               state_d = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         diff_q  <= '0;
         br_q    <= 1'b0;
         bout_q  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
         ovf_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         res_q   <= res_d;
         diff_q  <= diff_d;
         br_q    <= br_d;
         bout_q  <= bout_d;
`ifdef SERIAL_SUB_OVF_EN
         ovf_q   <= ovf_d;
`endif
      end
   end

   assign in_ready   = (state_q == IDLE) && !rst;
   assign out_valid  = (state_q == DONE);
   assign out_diff   = diff_q;
   assign out_borrow = bout_q;
`ifdef SERIAL_SUB_OVF_EN
   assign out_ovf    = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - directed scoreboard bench for serial_subtractor
module tb_serial_subtractor;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] in_a = '0;
   logic [W-1:0] in_b = '0;
   logic         in_borrow = 1'b0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [W-1:0] out_diff;
   logic         out_borrow;
`ifdef SERIAL_SUB_OVF_EN
   logic         out_ovf;
`endif

   int checks = 0;
   int errors = 0;
   logic [W+1:0] sb_q[$];

   serial_subtractor #(.WIDTH(W)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_a       (in_a),
      .in_b       (in_b),
      .in_borrow  (in_borrow),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_diff   (out_diff),
      .out_borrow (out_borrow)
`ifdef SERIAL_SUB_OVF_EN
      ,
      .out_ovf    (out_ovf)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Expected {ovf, borrow, diff} from plain integer arithmetic
   function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic bin);
      logic [W:0] full;
      int         s;
      logic       ovf;
      full = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bin};
      s    = int'($signed(a)) - int'($signed(b)) - int'(bin);
      ovf  = (s > (2 ** (W - 1)) - 1) || (s < -(2 ** (W - 1)));
      return {ovf, full[W], full[W-1:0]};
   endfunction

   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                         input int hold);
      logic [W+1:0] exp;
      int           n;
      int           lat;
      int           rdy_seen;
      n        = 0;
      lat      = 0;
      rdy_seen = 0;
      exp      = model(a, b, bin);
      while (!in_ready && n < 50) begin
         tick();
         n++;
      end
      check("ready_before_accept", in_ready, 1);
      out_ready = (hold == 0);
      in_a      = a;
      in_b      = b;
      in_borrow = bin;
      in_valid  = 1'b1;
      sb_q.push_back(exp);
      tick();
      in_valid = 1'b0;
      while (!out_valid && lat < 4 * W) begin
         if (in_ready) rdy_seen++;
         tick();
         lat++;
      end
      check("latency", lat, W);
      check("ready_low_in_shift", rdy_seen, 0);
      check("out_valid_rise", out_valid, 1);
      if (out_valid && sb_q.size() > 0) begin
         exp = sb_q.pop_front();
         check("diff", out_diff, exp[W-1:0]);
         check("borrow", out_borrow, exp[W]);
`ifdef SERIAL_SUB_OVF_EN
         check("ovf", out_ovf, exp[W+1]);
`endif
      end
      for (int i = 0; i < hold; i++) begin
         tick();
         check("bp_valid", out_valid, 1);
         check("bp_diff", out_diff, exp[W-1:0]);
         check("bp_borrow", out_borrow, exp[W]);
         check("bp_ready", in_ready, 0);
      end
      out_ready = 1'b1;
      tick();
      check("valid_drop", out_valid, 0);
      check("ready_after_done", in_ready, 1);
      out_ready = 1'b0;
   endtask

   initial begin
      int seen;
      rst = 1'b1;
      tick();
      tick();
      check("rst_in_ready", in_ready, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_diff", out_diff, 0);
      check("rst_out_borrow", out_borrow, 0);
`ifdef SERIAL_SUB_OVF_EN
      check("rst_out_ovf", out_ovf, 0);
`endif
      rst = 1'b0;
      #1;
      check("post_rst_in_ready", in_ready, 1);

      run_op(8'h35, 8'h12, 1'b0, 0);
      run_op(8'h00, 8'h01, 1'b0, 5);
      run_op(8'h80, 8'h01, 1'b0, 0);
      run_op(8'h10, 8'h0F, 1'b1, 0);
      run_op(8'h7F, 8'hFF, 1'b0, 2);
      for (int i = 0; i < 4; i++) begin
         run_op(W'($urandom), W'($urandom), 1'($urandom), i % 3);
      end

      // Abandon an operation with reset during its third shift cycle
      in_a     = 8'hAA;
      in_b     = 8'h55;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      #1;
      check("mid_rst_in_ready", in_ready, 0);
      tick();
      rst = 1'b0;
      #1;
      check("mid_rst_out_valid", out_valid, 0);
      check("mid_rst_in_ready_after", in_ready, 1);
      check("mid_rst_diff_cleared", out_diff, 0);
      check("mid_rst_borrow_cleared", out_borrow, 0);
      seen = 0;
      for (int i = 0; i < W + 4; i++) begin
         tick();
         if (out_valid) seen++;
      end
      check("aborted_no_valid", seen, 0);

      run_op(8'h05, 8'h03, 1'b0, 0);
      check("scoreboard_empty", sb_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

endmodule
